// File: rtl/lpbk_tx_framer.sv
// Loopback TX framer: drains header+payload qwords from the MAC FIFO
// and emits a 64-bit keep/last stream, dropping malformed frames.
module lpbk_tx_framer #(
  parameter int MAX_BYTES  = 1536,
  parameter int OBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        tx_fifo_rd,
  input  logic        tx_fifo_empty,
  input  logic [63:0] tx_fifo_dout,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        tx_underrun,
  output logic        err_zero,
  output logic        err_oversize,
  output logic [31:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int OW = $clog2(OBUF_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    DISCARD
  } state_t;

  state_t state, state_nx;

  logic [12:0] issue_left, issue_nx;
  logic [12:0] ret_left, ret_nx;
  logic [7:0]  lastkeep, lastkeep_nx;
  logic        pushed, pushed_nx;
  logic        pend;

  logic [63:0] mem_data [OBUF_DEPTH];
  logic [7:0]  mem_keep [OBUF_DEPTH];
  logic        mem_last [OBUF_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [OW-1:0] occ;

  logic [15:0] bc;
  logic [16:0] bc_sum;
  logic [12:0] words;
  logic        bc_zero, bc_big;
  logic        room, can_rd;
  logic        rd, push, pop;
  logic [7:0]  push_keep;
  logic        push_last;
  logic        ezero, eovs;

  assign bc      = tx_fifo_dout[15:0];
  assign bc_sum  = {1'b0, bc} + 17'd7;
  assign words   = bc_sum[15:3];
  assign bc_zero = (bc == 16'd0);
  assign bc_big  = (int'(bc) > MAX_BYTES);

  assign room   = (int'(occ) + int'(pend)) < (OBUF_DEPTH - 1);
  assign can_rd = !tx_fifo_empty && room && !reset;

  assign m_tvalid = (occ != '0);
  assign pop      = m_tvalid && m_tready;
  assign m_tdata  = mem_data[rd_ptr];
  assign m_tkeep  = mem_keep[rd_ptr];
  assign m_tlast  = mem_last[rd_ptr];

  assign tx_fifo_rd  = rd;
  assign tx_underrun = (state == DATA) && (occ == '0) && pushed;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (int'(p) == OBUF_DEPTH - 1)
      return '0;
    return p + PW'(1);
  endfunction

  always_comb begin
    state_nx    = state;
    issue_nx    = issue_left;
    ret_nx      = ret_left;
    lastkeep_nx = lastkeep;
    pushed_nx   = pushed;
    rd          = 1'b0;
    push        = 1'b0;
    push_keep   = 8'hFF;
    push_last   = 1'b0;
    ezero       = 1'b0;
    eovs        = 1'b0;
    unique case (state)
      IDLE: begin
        if (can_rd) begin
          rd       = 1'b1;
          state_nx = HDR;
        end
      end
      HDR: begin
        pushed_nx = 1'b0;
        if (bc[2:0] == 3'd0)
          lastkeep_nx = 8'hFF;
        else
          lastkeep_nx = (8'h1 << bc[2:0]) - 8'h1;
        if (bc_zero) begin
          ezero    = 1'b1;
          state_nx = IDLE;
        end else if (bc_big) begin
          eovs     = 1'b1;
          issue_nx = words;
          ret_nx   = words;
          state_nx = DISCARD;
        end else begin
          // first payload read overlaps header decode
          rd       = can_rd;
          issue_nx = words - {12'd0, can_rd};
          ret_nx   = words;
          state_nx = DATA;
        end
      end
      DATA: begin
        if (issue_left != '0 && can_rd) begin
          rd       = 1'b1;
          issue_nx = issue_left - 13'd1;
        end
        if (pend) begin
          push      = 1'b1;
          pushed_nx = 1'b1;
          ret_nx    = ret_left - 13'd1;
          if (ret_left == 13'd1) begin
            push_keep = lastkeep;
            push_last = 1'b1;
            state_nx  = IDLE;
            // fetch next header while the last word lands
            if (can_rd) begin
              rd       = 1'b1;
              state_nx = HDR;
            end
          end
        end
      end
      DISCARD: begin
        if (issue_left != '0 && can_rd) begin
          rd       = 1'b1;
          issue_nx = issue_left - 13'd1;
        end
        if (pend)
          ret_nx = ret_left - 13'd1;
        if (ret_left == '0 || (pend && ret_left == 13'd1))
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      issue_left <= '0;
      ret_left   <= '0;
      lastkeep   <= 8'hFF;
      pushed     <= 1'b0;
      pend       <= 1'b0;
    end else begin
      state      <= state_nx;
      issue_left <= issue_nx;
      ret_left   <= ret_nx;
      lastkeep   <= lastkeep_nx;
      pushed     <= pushed_nx;
      pend       <= rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_keep[i] <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= tx_fifo_dout;
        mem_keep[wr_ptr] <= push_keep;
        mem_last[wr_ptr] <= push_last;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      occ <= occ + OW'(push) - OW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt    <= '0;
      err_cnt      <= '0;
      err_zero     <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      err_zero     <= ezero;
      err_oversize <= eovs;
      if (pop && m_tlast)
        frame_cnt <= frame_cnt + 32'd1;
      if ((ezero || eovs) && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule
